// File: rtl/mag_comp_seq.sv
`default_nettype none
// ============================================================================
// Module   : mag_comp_seq
// Purpose  : Multi-cycle MSB-first magnitude comparator, CHUNK bits per clock,
//            early exit on first differing chunk, unsigned or signed compare.
// Revision : 1.0 - initial release
// ============================================================================
module mag_comp_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             aeqb,
  output logic             agb,
  output logic             alb
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] c_last = IW'(NCH - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sgn;
  logic [IW-1:0]    r_idx;
  logic             r_done;
  logic             r_aeqb;
  logic             r_agb;
  logic             r_alb;

  logic [CHUNK-1:0] w_mask;
  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic             w_ne;
  logic             w_gt;
  logic             w_last;

  // Signed mode inverts the sign bit of the MSB chunk only, turning the
  // two's-complement order into an unsigned one for that chunk.
  always_comb begin
    w_mask          = '0;
    w_mask[CHUNK-1] = r_sgn && (r_idx == c_last);
    w_ca            = r_a[int'(r_idx)*CHUNK +: CHUNK] ^ w_mask;
    w_cb            = r_b[int'(r_idx)*CHUNK +: CHUNK] ^ w_mask;
    w_ne            = (w_ca != w_cb);
    w_gt            = (w_ca > w_cb);
    w_last          = (r_idx == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_ne || w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_sgn  <= 1'b0;
      r_idx  <= '0;
      r_done <= 1'b0;
      r_aeqb <= 1'b0;
      r_agb  <= 1'b0;
      r_alb  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          r_a   <= a;
          r_b   <= b;
          r_sgn <= signed_mode;
          r_idx <= c_last;
        end
      end else if (w_ne) begin
        r_aeqb <= 1'b0;
        r_agb  <= w_gt;
        r_alb  <= !w_gt;
        r_done <= 1'b1;
      end else if (w_last) begin
        r_aeqb <= 1'b1;
        r_agb  <= 1'b0;
        r_alb  <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_idx <= r_idx - IW'(1);
      end
    end
  end

  assign done = r_done;
  assign aeqb = r_aeqb;
  assign agb  = r_agb;
  assign alb  = r_alb;

endmodule
`default_nettype wire

// File: doc/mag_comp_seq.md
Name: mag_comp_seq

Overview:
- Parametrised, multi-cycle successor to the team's 4-bit combinational magnitude comparator.
- Compares two WIDTH-bit operands MSB-first, CHUNK bits per clock, using a start/busy/done handshake.
- Terminates early at the first differing chunk.
- Supports unsigned and two's-complement signed modes; sits alongside datapath blocks that need wide compares without a long combinational path.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; CHUNK = WIDTH gives a single-cycle compare.
- NCH (localparam), WIDTH/CHUNK, number of chunks.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only when busy=0.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse when results update.
- aeqb  output  1  A == B.
- agb  output  1  A > B.
- alb  output  1  A < B.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: rst_n low immediately forces state=IDLE, busy=0, done=0, aeqb=agb=alb=0, chunk index=0, operand registers=0. This applies at any time, including mid-operation; the in-flight compare is discarded with no done.
- States:
  - IDLE: busy=0. A rising edge with start=1 latches a, b, signed_mode; sets idx=NCH-1 (MSB chunk); goes to RUN; busy=1 from that edge.
  - RUN: each edge compares chunk idx of the latched operands, a[idx*CHUNK +: CHUNK] vs b[...], unsigned.
    - Chunks unequal: set agb/alb per the chunk compare, aeqb=0, done=1; go to IDLE.
    - Chunks equal and idx=0: set aeqb=1, agb=alb=0, done=1; go to IDLE.
    - Otherwise: idx decrements; stay in RUN.
- Signed mode: in the MSB chunk only, the top bit of both operand chunks is inverted before comparing. Lower chunks are always compared unsigned.
- Latency: if start is accepted at edge T0 and k is the 1-based position of the first differing chunk from the MSB (k=NCH if the operands are equal):
  - results and done update at edge T0+k;
  - busy is high for exactly k cycles;
  - worst case is NCH cycles, best case is 1.
- done: high for exactly one cycle after each completion, deasserted on the following edge.
- Results:
  - aeqb/agb/alb hold their previous values while busy.
  - They change only at completion and then hold until the next completion.
  - After the first completion exactly one of the three is high.
- Handshake:
  - start while busy=1 is ignored; operands are not re-sampled and no queueing occurs.
  - start high in the done cycle (state IDLE) is accepted, giving back-to-back operation with no idle gap.
  - Holding start high continuously gives a new compare immediately after each completion.
- Operand inputs are don't-care when no start is being accepted.

Test Plan:
- Reset: rst_n=0 asserted asynchronously between clock edges -> busy, done, aeqb, agb and alb go 0 immediately, without waiting for a clock edge.
- Equal, unsigned (WIDTH=16, CHUNK=4): a=16'h1234, b=16'h1234, start 1 cycle -> busy high 4 cycles; done pulses at edge T0+4; aeqb=1, agb=0, alb=0.
- Early exit, signed/unsigned: a=16'h8000, b=16'h7FFF.
  - signed_mode=0 -> done at T0+1, agb=1.
  - Repeat with signed_mode=1 -> done at T0+1, alb=1.
- Mid-chunk difference: a=16'h12A4, b=16'h1254, unsigned -> done at T0+3, agb=1; a=16'hFFF0, b=16'hFFF1 signed -> done at T0+4, alb=1.
- Handshake:
  - Pulse start again while busy with different operands -> ignored; the result matches the first operands.
  - Start held high through a done cycle -> second compare begins at that edge, and busy stays high across the boundary except during the done cycle.
- Reset mid-op: a=16'h0001, b=16'h0000, rst_n low at T0+2 -> no done; outputs 0; after release, a fresh start completes normally with agb=1 at T0'+4.
